// File: rtl/simulate_data_gen.sv
// Synthetic burst traffic source: each En pulse emits BURST_LEN words taken from a
// free-running counter, with VALID_GAP idle cycles between consecutive words.
module simulate_data_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 256,
  parameter int VALID_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  En,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataOutValid,
  output logic                  Busy
);

  localparam int WW = $clog2(BURST_LEN + 1);
  localparam int GW = (VALID_GAP > 0) ? $clog2(VALID_GAP + 1) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(BURST_LEN);
  localparam logic [GW-1:0] GAP_END   = GW'(VALID_GAP);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                  state_q;
  state_t                  post_emit_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [WW-1:0]           words_q, words_d;
  logic [GW-1:0]           gap_q;
  logic                    valid_q;
  logic                    busy_q;

  // words_q is zero in IDLE, so the same increment serves the first word of a burst.
  // A one-word burst passes through SEND, which closes it on the following edge.
  always_comb begin
    words_d     = words_q + WW'(1);
    cnt_d       = cnt_q + DATA_WIDTH'(1);
    post_emit_d = (VALID_GAP > 0 && words_d != LAST_WORD) ? GAP : SEND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      words_q <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (En) begin
            dout_q  <= cnt_q;
            cnt_q   <= cnt_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            words_q <= words_d;
            gap_q   <= '0;
            state_q <= post_emit_d;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SEND: begin
          if (words_q == LAST_WORD) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            words_q <= '0;
            state_q <= IDLE;
          end else begin
            dout_q  <= cnt_q;
            cnt_q   <= cnt_d;
            valid_q <= 1'b1;
            words_q <= words_d;
            gap_q   <= '0;
            state_q <= post_emit_d;
          end
        end
        GAP: begin
          if (gap_q == GAP_END) begin
            dout_q  <= cnt_q;
            cnt_q   <= cnt_d;
            valid_q <= 1'b1;
            words_q <= words_d;
            gap_q   <= '0;
            state_q <= post_emit_d;
          end else begin
            valid_q <= 1'b0;
            gap_q   <= gap_q + GW'(1);
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          words_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DataOut      = dout_q;
  assign DataOutValid = valid_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_simulate_data_gen.sv
// Bench for simulate_data_gen: four parameterisations checked every cycle against a
// cycle-position model of the burst schedule, plus directed literal expectations.
module tb_simulate_data_gen;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NI];
  logic        en  [NI];
  logic        v   [NI];
  logic        b   [NI];
  logic [63:0] dout [NI];
  logic [63:0] d0;
  logic [15:0] d1;
  logic [7:0]  d2;
  logic [3:0]  d3;

  assign dout[0] = d0;
  assign dout[1] = 64'(d1);
  assign dout[2] = 64'(d2);
  assign dout[3] = 64'(d3);

  simulate_data_gen u0 (.clk(clk), .rst(rst[0]), .En(en[0]), .DataOut(d0),
                        .DataOutValid(v[0]), .Busy(b[0]));
  simulate_data_gen #(.DATA_WIDTH(16), .BURST_LEN(4), .VALID_GAP(2)) u1 (
    .clk(clk), .rst(rst[1]), .En(en[1]), .DataOut(d1), .DataOutValid(v[1]), .Busy(b[1]));
  simulate_data_gen #(.DATA_WIDTH(8), .BURST_LEN(150), .VALID_GAP(0)) u2 (
    .clk(clk), .rst(rst[2]), .En(en[2]), .DataOut(d2), .DataOutValid(v[2]), .Busy(b[2]));
  simulate_data_gen #(.DATA_WIDTH(4), .BURST_LEN(1), .VALID_GAP(3)) u3 (
    .clk(clk), .rst(rst[3]), .En(en[3]), .DataOut(d3), .DataOutValid(v[3]), .Busy(b[3]));

  function automatic int dw(int g);
    case (g) 0: return 64; 1: return 16; 2: return 8; default: return 4; endcase
  endfunction
  function automatic int bl(int g);
    case (g) 0: return 256; 1: return 4; 2: return 150; default: return 1; endcase
  endfunction
  function automatic int vg(int g);
    case (g) 0: return 0; 1: return 2; 2: return 0; default: return 3; endcase
  endfunction
  function automatic longint unsigned msk(int g);
    return (dw(g) == 64) ? {64{1'b1}} : ((64'd1 << dw(g)) - 64'd1);
  endfunction

  // Model: t counts cycles since the burst started; a word lands on every (gap+1)th
  // position until the occupancy B + (B-1)*G is used up.
  typedef struct packed {
    bit              active;
    int              t;
    longint unsigned cnt;
    longint unsigned dout;
    bit              valid;
    bit              busy;
  } mst_t;

  mst_t ms [NI];

  function automatic mst_t mstep(mst_t s, bit r, bit e, int g);
    mst_t n = s;
    int   occ = bl(g) + (bl(g) - 1) * vg(g);
    if (r) begin
      n.active = 0; n.t = 0; n.cnt = 0; n.dout = 0; n.valid = 0; n.busy = 0;
    end else if (s.active) begin
      n.t = s.t + 1;
      if (n.t >= occ) begin
        n.active = 0; n.valid = 0; n.busy = 0;
      end else begin
        n.busy = 1;
        if (n.t % (vg(g) + 1) == 0) begin
          n.valid = 1; n.dout = s.cnt; n.cnt = (s.cnt + 1) & msk(g);
        end else n.valid = 0;
      end
    end else if (e) begin
      n.active = 1; n.t = 0; n.valid = 1; n.busy = 1;
      n.dout = s.cnt; n.cnt = (s.cnt + 1) & msk(g);
    end else begin
      n.valid = 0; n.busy = 0;
    end
    return n;
  endfunction

  always @(posedge clk)
    for (int g = 0; g < NI; g++) ms[g] = mstep(ms[g], rst[g], en[g], g);

  int n_cmp = 0;
  int n_fail = 0;
  bit chk = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk)
      for (int g = 0; g < NI; g++) begin
        check($sformatf("u%0d.valid", g), 64'(v[g]), 64'(ms[g].valid));
        check($sformatf("u%0d.busy", g), 64'(b[g]), 64'(ms[g].busy));
        check($sformatf("u%0d.dout", g), dout[g], ms[g].dout);
      end

  // En is raised for exactly one edge; returns at the negedge showing the first word.
  task automatic pulse(input int g);
    en[g] = 1'b1;
    @(negedge clk);
    en[g] = 1'b0;
  endtask

  task automatic scan(input int g, input int ncyc, input int pulse_word,
                      output int nw, output int holes, output int bad, output int wraps,
                      output longint unsigned first, output longint unsigned last);
    longint unsigned cur, prev;
    nw = 0; holes = 0; bad = 0; wraps = 0; first = 0; last = 0; prev = 0;
    for (int c = 0; c < ncyc; c++) begin
      en[g] = 1'b0;
      if (v[g]) begin
        cur = dout[g];
        if (nw > 0) begin
          if (cur != ((prev + 1) & msk(g))) bad++;
          if (prev == msk(g) && cur == 0) wraps++;
        end else first = cur;
        if (pulse_word >= 0 && nw == pulse_word) en[g] = 1'b1;
        prev = cur; last = cur; nw++;
      end else if (nw > 0 && b[g]) holes++;
      @(negedge clk);
    end
    en[g] = 1'b0;
  endtask

  initial begin
    int nw, holes, bad, wraps, nv, nb;
    longint unsigned first, last;
    logic [13:0] pat;
    logic [63:0] wp;

    for (int g = 0; g < NI; g++) begin rst[g] = 1'b1; en[g] = 1'b0; end
    repeat (3) @(negedge clk);
    chk = 1;
    check("rst.dout", dout[0], 64'd0);
    check("rst.valid", 64'(v[0]), 64'd0);
    check("rst.busy", 64'(b[0]), 64'd0);
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;

    nv = 0;
    repeat (100) begin @(negedge clk); nv += int'(v[0]); end
    check("idle.valid_cycles", 64'(nv), 64'd0);

    pulse(0);
    scan(0, 300, -1, nw, holes, bad, wraps, first, last);
    check("b0.words", 64'(nw), 64'd256);
    check("b0.first", first, 64'd0);
    check("b0.last", last, 64'd255);
    check("b0.holes", 64'(holes + bad), 64'd0);

    repeat (200) @(negedge clk);
    pulse(0);
    scan(0, 300, -1, nw, holes, bad, wraps, first, last);
    check("b1.words", 64'(nw), 64'd256);
    check("b1.first", first, 64'd256);
    check("b1.last", last, 64'd511);
    check("b1.holes", 64'(holes + bad), 64'd0);

    pulse(0);
    scan(0, 600, 10, nw, holes, bad, wraps, first, last);
    check("ignored_en.words", 64'(nw), 64'd256);
    check("ignored_en.first", first, 64'd512);

    pulse(1);
    pat = '0; nb = 0; wp = '0;
    for (int c = 0; c < 14; c++) begin
      pat = {pat[12:0], v[1]};
      nb += int'(b[1]);
      if (v[1]) wp = {wp[47:0], dout[1][15:0]};
      @(negedge clk);
    end
    check("gap.valid_pattern", 64'(pat), 64'(14'b10010010010000));
    check("gap.busy_cycles", 64'(nb), 64'd10);
    check("gap.words", wp, 64'h0000_0001_0002_0003);

    pulse(2);
    scan(2, 200, -1, nw, holes, bad, wraps, first, last);
    check("w8.b0.last", last, 64'd149);
    pulse(2);
    scan(2, 200, -1, nw, holes, bad, wraps, first, last);
    check("w8.b1.first", first, 64'd150);
    check("w8.b1.last", last, 64'd43);
    check("w8.b1.wraps", 64'(wraps), 64'd1);
    check("w8.b1.bad_steps", 64'(bad), 64'd0);

    pulse(2);
    nw = 0;
    for (int c = 0; c < 200 && nw <= 100; c++) begin
      if (v[2]) nw++;
      if (nw <= 100) @(negedge clk);
    end
    check("w8.word100", dout[2], 64'd144);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    check("w8.rst.valid", 64'(v[2]), 64'd0);
    check("w8.rst.busy", 64'(b[2]), 64'd0);
    @(negedge clk);
    pulse(2);
    check("w8.restart.valid", 64'(v[2]), 64'd1);
    check("w8.restart.first", dout[2], 64'd0);
    repeat (200) @(negedge clk);

    en[1] = 1'b1; en[3] = 1'b1;
    repeat (40) @(negedge clk);
    en[1] = 1'b0; en[3] = 1'b0;

    repeat (3000) begin
      for (int g = 0; g < NI; g++) begin
        en[g]  = ($urandom_range(0, 5) == 0);
        rst[g] = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk);
    end
    for (int g = 0; g < NI; g++) begin en[g] = 1'b0; rst[g] = 1'b0; end
    repeat (5) @(negedge clk);

    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
